// File: rtl/count_sequencer_pkg.sv
// Shared constants for the LED counter sequencer: FSM encoding and default timing.
// Latency: n/a (constants only).
// Backpressure: n/a; the counter datapath always accepts commands.
package count_sequencer_pkg;

    // Sequencer states; two bits, one code left unused.
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // Board defaults for a 10 MHz gclk10: one step per second, 10 ms debounce.
    localparam int DEF_TICK_DIV        = 10000000;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;

endpackage

// File: rtl/count_sequencer_input_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw board input.
// Latency: output follows a stable input change after 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running every cycle.
module count_sequencer_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic deb_out
);

    // Wide enough to hold DEBOUNCE_CYCLES-1 even when DEBOUNCE_CYCLES is 1.
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples that disagree with the debounced value; any agreeing
    // sample restarts the count, and the final disagreeing sample commits the change.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer stages and debounce state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_out = deb_q;

endmodule

// File: rtl/count_sequencer.sv
// Sequences the up/down LED counter: debounced controls, step prescaler, bounce reflection.
// Latency: cnt_en/cnt_up one cycle after the internal tick; cnt_clr in the first cycle out of reset.
// Backpressure: none; the counter consumes every one-cycle command pulse.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             gclk10,
    input  logic             btn_center,
    input  logic             sw_0,
    input  logic             sw_1,
    input  logic             btn_pause,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             paused
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN    = '0;

    logic dir_sw;
    logic mode_sw;
    logic pause_db;
    logic pause_rise;

    logic [1:0]    state_q,      state_d;
    logic [PW-1:0] presc_q,      presc_d;
    logic          dir_q,        dir_d;
    logic          pause_prev_q, pause_prev_d;
    logic          cnt_en_q,     cnt_en_d;
    logic          cnt_up_q,     cnt_up_d;
    logic          step_dir;

    count_sequencer_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dir (
        .clk     (gclk10),
        .rst     (btn_center),
        .raw_in  (sw_0),
        .deb_out (dir_sw)
    );

    count_sequencer_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk     (gclk10),
        .rst     (btn_center),
        .raw_in  (sw_1),
        .deb_out (mode_sw)
    );

    count_sequencer_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pause (
        .clk     (gclk10),
        .rst     (btn_center),
        .raw_in  (btn_pause),
        .deb_out (pause_db)
    );

    assign pause_rise = pause_db & ~pause_prev_q;

    // Direction for a step taken this cycle: follow the switch in wrap mode, reflect at
    // the end stops in bounce mode so the counter never steps past 0 or the maximum.
    always_comb begin
        step_dir = dir_q;
        if (!mode_sw) begin
            step_dir = ~dir_sw;
        end else if (dir_q && (cnt_value == CNT_MAX)) begin
            step_dir = 1'b0;
        end else if (!dir_q && (cnt_value == CNT_MIN)) begin
            step_dir = 1'b1;
        end
    end

    // Sequencer FSM and prescaler; a pause edge overrides a coincident tick, and on resume
    // the edge cycle counts as prescaler phase 0 so the step lands TICK_DIV cycles later.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        dir_d        = dir_q;
        pause_prev_d = pause_db;
        cnt_en_d     = 1'b0;
        cnt_up_d     = cnt_up_q;
        case (state_q)
            S_CLEAR: begin
                state_d = S_RUN;
                presc_d = '0;
            end
            S_RUN: begin
                if (pause_rise) begin
                    state_d = S_PAUSE;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    cnt_en_d = 1'b1;
                    dir_d    = step_dir;
                    cnt_up_d = step_dir;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (pause_rise) begin
                    state_d = S_RUN;
                    presc_d = PW'(1);
                end else begin
                    presc_d = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                presc_d = '0;
            end
        endcase
    end

    // Sequencer state registers; reset drops any pending step.
    always_ff @(posedge gclk10) begin
        if (btn_center) begin
            state_q      <= S_CLEAR;
            presc_q      <= '0;
            dir_q        <= 1'b0;
            pause_prev_q <= 1'b0;
            cnt_en_q     <= 1'b0;
            cnt_up_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            dir_q        <= dir_d;
            pause_prev_q <= pause_prev_d;
            cnt_en_q     <= cnt_en_d;
            cnt_up_q     <= cnt_up_d;
        end
    end

    // Clear is issued in the single S_CLEAR cycle once reset has been released.
    assign cnt_clr = (state_q == S_CLEAR) & ~btn_center;
    assign cnt_en  = cnt_en_q;
    assign cnt_up  = cnt_up_q;
    assign paused  = (state_q == S_PAUSE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Each row drives inputs for one cycle and checks {cnt_clr,cnt_en,cnt_up,paused}.
// Expected values are hand-derived per cycle.
module tb_count_sequencer;

    logic       gclk10     = 1'b0;
    logic       btn_center = 1'b1;
    logic       sw_0       = 1'b0;
    logic       sw_1       = 1'b0;
    logic       btn_pause  = 1'b0;
    logic [7:0] cnt_value  = 8'd0;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_up;
    logic       paused;

    int n_vec = 0;
    int n_bad = 0;
    int row   = 0;

    typedef struct {
        int         rep;
        logic       rst;
        logic       s0;
        logic       s1;
        logic       p;
        logic [7:0] cv;
        logic [3:0] exp_o;   // {clr, en, up, paused}
    } vec_t;

    vec_t tbl[$];

    always #5 gclk10 = ~gclk10;

    count_sequencer #(
        .WIDTH           (8),
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .gclk10     (gclk10),
        .btn_center (btn_center),
        .sw_0       (sw_0),
        .sw_1       (sw_1),
        .btn_pause  (btn_pause),
        .cnt_value  (cnt_value),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_up     (cnt_up),
        .paused     (paused)
    );

    function automatic vec_t mk(input int rep, input logic rst, input logic s0, input logic s1,
                                input logic p, input logic [7:0] cv, input logic [3:0] e);
        vec_t v;
        v.rep = rep; v.rst = rst; v.s0 = s0; v.s1 = s1; v.p = p; v.cv = cv; v.exp_o = e;
        return v;
    endfunction

    // Drive one row per cycle just after the edge, check outputs at the falling edge.
    task automatic rows(input string nm, input int rep, input logic rst, input logic s0,
                        input logic s1, input logic p, input logic [7:0] cv, input logic [3:0] e);
        logic [3:0] got;
        for (int i = 0; i < rep; i++) begin
            @(posedge gclk10);
            #1;
            btn_center = rst;
            sw_0       = s0;
            sw_1       = s1;
            btn_pause  = p;
            cnt_value  = cv;
            @(negedge gclk10);
            got = {cnt_clr, cnt_en, cnt_up, paused};
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s row %0d: clr,en,up,paused = %b, expected %b", nm, row, got, e);
            end
            row++;
        end
    endtask

    initial begin
        // Reset, release with wrap/up, glitch-free direction change, then a 2-cycle glitch.
        tbl.push_back(mk(3, 1, 0, 0, 0, 8'd0, 4'b0000));   // held in reset
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'd0, 4'b1000));   // clear pulse
        tbl.push_back(mk(4, 0, 0, 0, 0, 8'd0, 4'b0000));   // prescaler 0..3
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'd0, 4'b0110));   // first step, up
        tbl.push_back(mk(3, 0, 1, 0, 0, 8'd0, 4'b0010));   // sw_0 raised
        tbl.push_back(mk(1, 0, 1, 0, 0, 8'd0, 4'b0110));   // debounce not yet done
        tbl.push_back(mk(3, 0, 1, 0, 0, 8'd0, 4'b0010));
        tbl.push_back(mk(1, 0, 1, 0, 0, 8'd0, 4'b0100));   // step now down
        tbl.push_back(mk(1, 0, 1, 0, 0, 8'd0, 4'b0000));
        tbl.push_back(mk(2, 0, 0, 0, 0, 8'd0, 4'b0000));   // 2-cycle glitch low
        tbl.push_back(mk(1, 0, 1, 0, 0, 8'd0, 4'b0100));   // still down
        tbl.push_back(mk(3, 0, 1, 0, 0, 8'd0, 4'b0000));
        tbl.push_back(mk(1, 0, 1, 0, 0, 8'd0, 4'b0100));

        foreach (tbl[k]) begin
            rows("wrap_tbl", tbl[k].rep, tbl[k].rst, tbl[k].s0, tbl[k].s1, tbl[k].p,
                 tbl[k].cv, tbl[k].exp_o);
        end

        // Pause on a debounced press, release, then resume with step 4 cycles after the edge.
        rows("pause_run",     3, 0, 1, 0, 1, 8'd0, 4'b0000);
        rows("pause_run_en",  1, 0, 1, 0, 1, 8'd0, 4'b0100);
        rows("pause_edge",    2, 0, 1, 0, 1, 8'd0, 4'b0000);
        rows("paused_rel",    7, 0, 1, 0, 0, 8'd0, 4'b0001);
        rows("paused_press",  6, 0, 1, 0, 1, 8'd0, 4'b0001);
        rows("resume_gap",    3, 0, 1, 0, 1, 8'd0, 4'b0000);
        rows("resume_step",   1, 0, 1, 0, 1, 8'd0, 4'b0100);

        // Bounce mode: reflect at 0 and at 255, ignore sw_0, hold direction mid-range.
        rows("bnc_settle",    3, 0, 1, 1, 1, 8'd0,   4'b0000);
        rows("bnc_wrap_step", 1, 0, 1, 1, 1, 8'd0,   4'b0100);
        rows("bnc_settle2",   3, 0, 1, 1, 1, 8'd0,   4'b0000);
        rows("bnc_lo_turn",   1, 0, 0, 1, 1, 8'd100, 4'b0110);
        rows("bnc_mid",       3, 0, 0, 1, 1, 8'd100, 4'b0010);
        rows("bnc_mid_step",  1, 0, 0, 1, 1, 8'd255, 4'b0110);
        rows("bnc_at_max",    3, 0, 0, 1, 1, 8'd255, 4'b0010);
        rows("bnc_hi_turn",   1, 0, 1, 1, 1, 8'd0,   4'b0100);
        rows("bnc_down",      3, 0, 1, 1, 1, 8'd0,   4'b0000);
        rows("bnc_lo_turn2",  1, 0, 1, 1, 1, 8'd0,   4'b0110);
        rows("bnc_up_at0",    3, 0, 1, 1, 1, 8'd0,   4'b0010);
        rows("bnc_up_hold",   1, 0, 1, 1, 1, 8'd0,   4'b0110);

        // Pause edge lands exactly on a tick: step suppressed, paused next cycle.
        rows("coinc_rel",     3, 0, 1, 1, 0, 8'd0, 4'b0010);
        rows("coinc_step",    1, 0, 1, 1, 0, 8'd0, 4'b0110);
        rows("coinc_rel2",    1, 0, 1, 1, 0, 8'd0, 4'b0010);
        rows("coinc_press",   2, 0, 1, 1, 1, 8'd0, 4'b0010);
        rows("coinc_step2",   1, 0, 1, 1, 1, 8'd0, 4'b0110);
        rows("coinc_tick",    3, 0, 1, 1, 1, 8'd0, 4'b0010);
        rows("coinc_paused",  6, 0, 1, 1, 0, 8'd0, 4'b0011);

        // Resume, then reset in the tick cycle: step dropped, clear reissued, cadence restarts.
        rows("rst_press",     6, 0, 1, 1, 1, 8'd0, 4'b0011);
        rows("rst_run",       2, 0, 1, 1, 0, 8'd0, 4'b0010);
        rows("rst_at_tick",   1, 1, 0, 0, 0, 8'd0, 4'b0010);
        rows("rst_held",      2, 1, 0, 0, 0, 8'd0, 4'b0000);
        rows("rst_clr",       1, 0, 0, 0, 0, 8'd0, 4'b1000);
        rows("rst_gap",       4, 0, 0, 0, 0, 8'd0, 4'b0000);
        rows("rst_step1",     1, 0, 0, 0, 0, 8'd0, 4'b0110);
        rows("rst_gap2",      3, 0, 0, 0, 0, 8'd0, 4'b0010);
        rows("rst_step2",     1, 0, 0, 0, 0, 8'd0, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences the 8-bit up/down LED counter datapath. It sits between the raw board inputs and the counter.
- Debounces the direction switch, mode switch and pause button.
- Divides gclk10 down to a visible step rate.
- Issues one-cycle step, direction and clear commands to the counter.
- In bounce mode, reads the counter value back and reverses direction at the end stops.

Parameters:
WIDTH, 8, counter width; cnt_value and end-stop compare width
TICK_DIV, 10000000, gclk10 cycles per step (legal range >= 2)
DEBOUNCE_CYCLES, 100000, consecutive stable samples before a debounced input changes (legal range >= 1)

Ports:
gclk10  in  1  system clock; single clock domain
btn_center  in  1  reset; synchronous, active-high
sw_0  in  1  raw direction switch (0 = count up, 1 = count down); asynchronous
sw_1  in  1  raw mode switch (0 = wrap, 1 = bounce); asynchronous
btn_pause  in  1  raw pause/resume button; asynchronous
cnt_value  in  WIDTH  current counter value, fed back from the datapath
cnt_clr  out  1  one-cycle pulse; counter loads 0
cnt_en  out  1  one-cycle step pulse
cnt_up  out  1  step direction (1 = up); qualified by cnt_en
paused  out  1  status LED; high while in S_PAUSE

Behaviour:
Reset:
- While btn_center=1, all outputs are 0 and state=S_CLEAR.
- Prescaler, debounced values and dir_reg are cleared to 0.

Input conditioning:
- Each raw input passes a 2-flop synchronizer, then a debounce counter.
- The debounced value changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
- Any sample equal to the current debounced value resets the count.
- Input-to-debounced-output latency = 2 + DEBOUNCE_CYCLES cycles.

States:
- S_CLEAR: cnt_clr=1 for exactly one cycle, in the first cycle after btn_center falls; go to S_RUN.
- S_RUN: prescaler counts 0..TICK_DIV-1; tick is asserted internally when prescaler==TICK_DIV-1, then prescaler returns to 0.
- S_PAUSE: prescaler held at 0; cnt_en=0; paused=1.

Transitions:
- A rising edge of debounced btn_pause toggles S_RUN <-> S_PAUSE.
- On resume, the prescaler restarts from 0, so the first cnt_en comes TICK_DIV cycles after the edge.
- If a pause edge and a tick occur in the same cycle, the pause edge wins: no cnt_en, enter S_PAUSE.

Step generation (decided in the tick cycle t; cnt_en and cnt_up registered, valid at t+1):
- Wrap mode (debounced sw_1=0):
  - dir_reg <= ~debounced sw_0.
  - The counter wraps naturally; cnt_value is ignored.
- Bounce mode (debounced sw_1=1):
  - If dir_reg=1 and cnt_value == 2^WIDTH-1: dir_reg <= 0.
  - Else if dir_reg=0 and cnt_value == 0: dir_reg <= 1.
  - Else dir_reg is unchanged.
  - sw_0 is ignored.
- Mode is sampled at the tick cycle.
- On a wrap-to-bounce change, dir_reg starts from its current value.
- cnt_up = dir_reg as updated in cycle t. There is no step toward an end stop: bounce reflects, never wraps.

Other rules:
- cnt_en is never high in the same cycle as cnt_clr.
- cnt_up holds its last value between steps.
- btn_center asserted mid-operation: outputs go to 0 in the next cycle, any pending cnt_en is dropped, and the S_CLEAR pulse is reissued on release.

Decomposition:
- Shared package holds: state encoding constants (S_CLEAR, S_RUN, S_PAUSE, 2 bits) and the default TICK_DIV / DEBOUNCE_CYCLES constants shared with the top level.
- One natural sub-module: input_debounce (synchronizer + stability counter, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
All scenarios use TICK_DIV=4 and DEBOUNCE_CYCLES=3.
1. Reset release with sw_0=0, sw_1=0 -> cnt_clr=1 in exactly the first cycle after btn_center falls; cnt_en pulses every 4 cycles with cnt_up=1; paused=0.
2. Set sw_0=1 and hold it -> debounced change after 5 cycles; the next cnt_en after that carries cnt_up=0. A 2-cycle glitch on sw_0 -> no direction change.
3. btn_pause rising edge held 3+ cycles -> paused=1 and no cnt_en while paused; a second press resumes, with the first cnt_en exactly 4 cycles after the debounced edge.
4. Bounce mode, cnt_value=255, dir up, tick -> cnt_en with cnt_up=0. Then cnt_value=0 at the next tick -> cnt_up=1; sw_0 toggles have no effect.
5. Pause edge forced coincident with a tick -> no cnt_en that cycle; paused=1 next cycle.
6. btn_center asserted mid-run, one cycle before a scheduled cnt_en -> cnt_en suppressed, all outputs 0; after release, a single cnt_clr pulse, then a normal 4-cycle step cadence.
